hash_tte_bucket_nway: RTL and testbench

N-way set-associative flow table for time-triggered (TTE) forwarding, keyed by {destination MAC, source MAC} and indexed by an externally computed hash. It is the parametrised successor of the single-way TTE bucket: configurable depth, associativity and portmap width, plus collision handling with insert/overwrite/full reporting. It sits between the hash generator and the forwarding engine's lookup port.

---
 rtl/hash_tte_bucket_nway_if.sv | 43 ++++
 rtl/hash_tte_bucket_nway.sv | 180 ++++++++++++++++++
 tb/tb_hash_tte_bucket_nway.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hash_tte_bucket_nway_if.sv
// Request/response bundle between the hash generator, forwarding engine and the
// N-way TTE flow table.
interface hash_tte_bucket_nway_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned PORT_W = 16
);
    logic                  se_req;
    logic [ADDR_W-1:0]     se_hash;
    logic [47:0]           se_dmac;
    logic [47:0]           se_smac;
    logic                  se_ack;
    logic                  se_nak;
    logic [PORT_W-1:0]     se_result;

    logic                  upd_req;
    logic [ADDR_W-1:0]     upd_hash;
    logic [97+PORT_W-1:0]  upd_flow;
    logic                  upd_done;
    logic                  upd_fail;

    logic                  hash_clear;
    logic                  clr_done;
    logic                  busy;

    modport master (
        output se_req, se_hash, se_dmac, se_smac,
        input  se_ack, se_nak, se_result,
        output upd_req, upd_hash, upd_flow,
        input  upd_done, upd_fail,
        output hash_clear,
        input  clr_done, busy
    );

    modport slave (
        input  se_req, se_hash, se_dmac, se_smac,
        output se_ack, se_nak, se_result,
        input  upd_req, upd_hash, upd_flow,
        output upd_done, upd_fail,
        input  hash_clear,
        output clr_done, busy
    );
endinterface

// File: rtl/hash_tte_bucket_nway.sv
// N-way set-associative TTE flow table keyed by {dmac, smac}, row chosen by external hash.
// Optional feature macro: HASH_TTE_DELETE_EN (update with valid=0 invalidates a matching way).
module hash_tte_bucket_nway #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned PORT_W = 16
) (
    input logic                    clk,
    input logic                    rstn,
    hash_tte_bucket_nway_if.slave  bus
);
    localparam int unsigned EW    = 97 + PORT_W;
    localparam int unsigned RW    = WAYS * EW;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        StClear, StIdle, StSrd, StScmp, StSrsp, StUrd, StUcmp, StUwr, StUrsp
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W:0]   clr_cnt_q;
    logic              clr_pend_q;
    logic [ADDR_W-1:0] hash_q;
    logic [EW-1:0]     flow_q;
    logic [RW-1:0]     row_q;
    logic [RW-1:0]     rd_data;
    logic [PORT_W-1:0] result_q;
    logic [RW-1:0]     mem [DEPTH];

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [RW-1:0]     ram_wdata;

    logic              match;
    logic              free;
    int                match_idx;
    int                free_idx;
    logic [EW-1:0]     ent;
    logic [PORT_W-1:0] hit_port;
    logic              upd_we;
    logic [RW-1:0]     wr_row;

    // Way scan runs high to low so the lowest-index way wins.
    always_comb begin
        match     = 1'b0;
        free      = 1'b0;
        match_idx = 0;
        free_idx  = 0;
        ent       = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            ent = row_q[w*EW +: EW];
            if (ent[EW-1] && (ent[PORT_W +: 96] == flow_q[PORT_W +: 96])) begin
                match     = 1'b1;
                match_idx = w;
            end
            if (!ent[EW-1]) begin
                free     = 1'b1;
                free_idx = w;
            end
        end
        hit_port = row_q[match_idx*EW +: PORT_W];
    end

    always_comb begin
        wr_row = row_q;
        upd_we = 1'b0;
        if (flow_q[EW-1]) begin
            if (match) begin
                wr_row[match_idx*EW +: EW] = flow_q;
                upd_we = 1'b1;
            end else if (free) begin
                wr_row[free_idx*EW +: EW] = flow_q;
                upd_we = 1'b1;
            end
        end
`ifdef HASH_TTE_DELETE_EN
        else if (match) begin
            wr_row[match_idx*EW +: EW] = '0;
            upd_we = 1'b1;
        end
`endif
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = hash_q;
        ram_wdata = wr_row;
        if (state_q == StClear && !clr_cnt_q[ADDR_W]) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q[ADDR_W-1:0];
            ram_wdata = '0;
        end else if (state_q == StUwr) begin
            ram_we = upd_we;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_data <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StClear: if (clr_cnt_q[ADDR_W]) state_d = StIdle;
            StIdle: begin
                if (bus.hash_clear || clr_pend_q) begin
                    state_d = StClear;
                end else if (bus.upd_req) begin
                    state_d = StUrd;
                end else if (bus.se_req) begin
                    state_d = StSrd;
                end
            end
            StSrd:   state_d = StScmp;
            StScmp:  state_d = StSrsp;
            StSrsp:  state_d = StIdle;
            StUrd:   state_d = StUcmp;
            StUcmp:  state_d = StUwr;
            StUwr:   state_d = StUrsp;
            StUrsp:  state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_cnt_q  <= '0;
            clr_pend_q <= 1'b0;
            hash_q     <= '0;
            flow_q     <= '0;
            row_q      <= '0;
            result_q   <= '0;
        end else begin
            clr_cnt_q <= (state_q == StClear) ? clr_cnt_q + 1'b1 : '0;
            if (state_d == StClear) begin
                clr_pend_q <= 1'b0;
            end else if (bus.hash_clear && state_q != StClear) begin
                clr_pend_q <= 1'b1;
            end
            // Search key reuses the flow register; portmap field is don't-care for matching.
            if (state_q == StIdle) begin
                if (bus.upd_req) begin
                    hash_q <= bus.upd_hash;
                    flow_q <= bus.upd_flow;
                end else begin
                    hash_q <= bus.se_hash;
                    flow_q <= {1'b1, bus.se_smac, bus.se_dmac, {PORT_W{1'b0}}};
                end
            end
            if (state_q == StScmp || state_q == StUcmp) begin
                row_q <= rd_data;
            end
            if (state_q == StSrsp && match) begin
                result_q <= hit_port;
            end
        end
    end

    always_comb begin
        bus.se_ack    = (state_q == StSrsp) && match;
        bus.se_nak    = (state_q == StSrsp) && !match;
        bus.se_result = ((state_q == StSrsp) && match) ? hit_port : result_q;
        bus.upd_done  = (state_q == StUrsp);
        bus.upd_fail  = (state_q == StUrsp) && !upd_we;
        bus.clr_done  = (state_q == StClear) && clr_cnt_q[ADDR_W];
        bus.busy      = (state_q != StIdle);
    end
endmodule

// File: tb/tb_hash_tte_bucket_nway.sv
// Scoreboard bench for hash_tte_bucket_nway: drivers push expected responses, a negedge
// monitor pops and compares whenever the table answers.
module tb_hash_tte_bucket_nway;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned PORT_W = 16;

    typedef struct {
        int          kind;  // 0 search, 1 update, 2 clear
        logic        hit;
        logic [15:0] port;
        logic        fail;
        int          issue;
        int          lat;   // -1: latency not checked
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   vectors = 0;
    int   misses  = 0;
    exp_t expq[$];
    exp_t mon_e;
    int   mon_kind;
    logic [15:0] last_port = 16'h0;

    localparam logic [47:0] AD = 48'h244bfe586128, AS = 48'h000ec657ff9d;
    localparam logic [47:0] BD = 48'h0123456789ab, BS = 48'ha1b2c3d4e5f6;
    localparam logic [47:0] CD = 48'hffffffffffff, CS = 48'h000000000001;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hash_tte_bucket_nway_if #(.ADDR_W(ADDR_W), .WAYS(WAYS), .PORT_W(PORT_W)) bus ();

    hash_tte_bucket_nway #(.ADDR_W(ADDR_W), .WAYS(WAYS), .PORT_W(PORT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            misses++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && (bus.se_ack || bus.se_nak || bus.upd_done || bus.clr_done)) begin
            mon_kind = bus.clr_done ? 2 : (bus.upd_done ? 1 : 0);
            if (expq.size() == 0) begin
                vectors++;
                misses++;
                $display("FAIL unexpected_resp: got kind %0d, expected none", mon_kind);
            end else begin
                mon_e = expq.pop_front();
                check("resp_kind", 64'(mon_kind), 64'(mon_e.kind));
                if (mon_e.kind == mon_kind) begin
                    if (mon_e.lat >= 0) check("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
                    if (mon_kind == 0) begin
                        check("se_hit", 64'(bus.se_ack), 64'(mon_e.hit));
                        if (mon_e.hit) begin
                            check("se_result", 64'(bus.se_result), 64'(mon_e.port));
                            last_port = mon_e.port;
                        end else begin
                            check("se_result_hold", 64'(bus.se_result), 64'(last_port));
                        end
                    end else if (mon_kind == 1) begin
                        check("upd_fail", 64'(bus.upd_fail), 64'(mon_e.fail));
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(bus.busy), 64'(0));
    endtask

    task automatic wait_resp(input bit is_se, input int bound);
        int n = 0;
        logic got;
        do begin
            @(negedge clk);
            n++;
            got = is_se ? (bus.se_ack | bus.se_nak) : bus.upd_done;
        end while (!got && n < bound);
        check("resp_arrived", 64'(got), 64'(1));
    endtask

    task automatic search(input logic [9:0] h, input logic [47:0] d, input logic [47:0] s,
                          input logic exp_hit, input logic [15:0] exp_port);
        wait_idle(3000);
        bus.se_hash = h;
        bus.se_dmac = d;
        bus.se_smac = s;
        bus.se_req  = 1'b1;
        expq.push_back('{kind: 0, hit: exp_hit, port: exp_port, fail: 1'b0, issue: cyc, lat: 3});
        wait_resp(1'b1, 20);
        bus.se_req = 1'b0;
    endtask

    task automatic update(input logic [9:0] h, input logic v, input logic [47:0] d,
                          input logic [47:0] s, input logic [15:0] p, input logic exp_fail);
        wait_idle(3000);
        bus.upd_hash = h;
        bus.upd_flow = {v, s, d, p};
        bus.upd_req  = 1'b1;
        expq.push_back('{kind: 1, hit: 1'b0, port: 16'h0, fail: exp_fail, issue: cyc, lat: 4});
        wait_resp(1'b0, 20);
        bus.upd_req = 1'b0;
    endtask

    initial begin
        bus.se_req     = 1'b0;
        bus.se_hash    = '0;
        bus.se_dmac    = '0;
        bus.se_smac    = '0;
        bus.upd_req    = 1'b0;
        bus.upd_hash   = '0;
        bus.upd_flow   = '0;
        bus.hash_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_se_ack",    64'(bus.se_ack),    64'(0));
        check("rst_se_nak",    64'(bus.se_nak),    64'(0));
        check("rst_se_result", 64'(bus.se_result), 64'(0));
        check("rst_upd_done",  64'(bus.upd_done),  64'(0));
        check("rst_upd_fail",  64'(bus.upd_fail),  64'(0));
        check("rst_clr_done",  64'(bus.clr_done),  64'(0));
        check("rst_busy",      64'(bus.busy),      64'(1));
        // Writes happen on the 1024 edges after release; clr_done follows the last one.
        expq.push_back('{kind: 2, hit: 1'b0, port: 16'h0, fail: 1'b0, issue: cyc, lat: 1024});
        rstn = 1'b1;
        wait_idle(3000);

        search(10'h128, AD, AS, 1'b0, 16'h0);
        update(10'h128, 1'b1, AD, AS, 16'h0001, 1'b0);
        search(10'h128, AD, AS, 1'b1, 16'h0001);
        update(10'h128, 1'b1, BD, BS, 16'h0002, 1'b0);
        update(10'h128, 1'b1, CD, CS, 16'h0008, 1'b1);
        search(10'h128, AD, AS, 1'b1, 16'h0001);
        search(10'h128, BD, BS, 1'b1, 16'h0002);
        search(10'h128, CD, CS, 1'b0, 16'h0);
        update(10'h128, 1'b1, AD, AS, 16'h0004, 1'b0);
        search(10'h128, AD, AS, 1'b1, 16'h0004);
        search(10'h128, BD, BS, 1'b1, 16'h0002);
        search(10'h128, AS, AD, 1'b0, 16'h0);
        search(10'h129, AD, AS, 1'b0, 16'h0);
`ifdef HASH_TTE_DELETE_EN
        update(10'h128, 1'b0, AD, AS, 16'h0, 1'b0);
        search(10'h128, AD, AS, 1'b0, 16'h0);
        update(10'h128, 1'b1, CD, CS, 16'h0008, 1'b0);
        search(10'h128, CD, CS, 1'b1, 16'h0008);
        search(10'h128, BD, BS, 1'b1, 16'h0002);
`else
        update(10'h128, 1'b0, AD, AS, 16'h0, 1'b1);
        search(10'h128, AD, AS, 1'b1, 16'h0004);
`endif
        update(10'h3ff, 1'b1, BD, AS, 16'h8001, 1'b0);
        update(10'h000, 1'b1, AD, BS, 16'h7ffe, 1'b0);
        search(10'h3ff, BD, AS, 1'b1, 16'h8001);
        search(10'h000, AD, BS, 1'b1, 16'h7ffe);
        search(10'h000, BD, AS, 1'b0, 16'h0);

        // Update and search raised together, clear pulsed mid-update.
        wait_idle(3000);
        bus.upd_hash = 10'h055;
        bus.upd_flow = {1'b1, CS, CD, 16'h0040};
        bus.se_hash  = 10'h055;
        bus.se_dmac  = CD;
        bus.se_smac  = CS;
        bus.upd_req  = 1'b1;
        bus.se_req   = 1'b1;
        expq.push_back('{kind: 1, hit: 1'b0, port: 16'h0, fail: 1'b0, issue: cyc, lat: 4});
        expq.push_back('{kind: 2, hit: 1'b0, port: 16'h0, fail: 1'b0, issue: cyc, lat: -1});
        expq.push_back('{kind: 0, hit: 1'b0, port: 16'h0, fail: 1'b0, issue: cyc, lat: -1});
        @(negedge clk);
        @(negedge clk);
        bus.hash_clear = 1'b1;
        @(negedge clk);
        bus.hash_clear = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.upd_done) bus.upd_req = 1'b0;
            if (bus.se_ack || bus.se_nak) break;
        end
        check("concurrent_resp", 64'(bus.se_ack | bus.se_nak), 64'(1));
        bus.se_req  = 1'b0;
        bus.upd_req = 1'b0;

        search(10'h128, BD, BS, 1'b0, 16'h0);
        search(10'h3ff, BD, AS, 1'b0, 16'h0);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(expq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
